ibuffer: RTL and testbench

- Instruction buffer between the frontend fetch output and the decode stage.
- Accepts one fetch group per handshake and keeps only the slots whose `slot_valid` bit is set, packing them in slot order.
- Attaches a per-instruction PC and predicted next PC to each kept slot, then stores them in a circular FIFO.
- Presents up to DECODE_WIDTH instructions per cycle to decode in program order; flush discards all contents.

---
 rtl/ibuffer.sv | 105 ++++++++++
 tb/tb_ibuffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ibuffer.sv
// Instruction buffer: packs valid fetch slots into a circular FIFO and presents
// up to DECODE_WIDTH entries to decode in program order; flush/reset empty it.
module ibuffer #(
  parameter int INSTR_PER_FETCH = 4,
  parameter int DECODE_WIDTH    = 4,
  parameter int DEPTH           = 16,
  parameter int ILEN            = 32,
  parameter int PLEN            = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            fe_valid_i,
  output logic                            fe_ready_o,
  input  logic [INSTR_PER_FETCH*ILEN-1:0] fe_data_i,
  input  logic [PLEN-1:0]                 fe_pc_i,
  input  logic [INSTR_PER_FETCH-1:0]      fe_slot_valid_i,
  input  logic [INSTR_PER_FETCH*PLEN-1:0] fe_pred_npc_i,
  input  logic                            flush_i,
  output logic [DECODE_WIDTH-1:0]         de_valid_o,
  input  logic                            de_ready_i,
  output logic [DECODE_WIDTH*ILEN-1:0]    de_instr_o,
  output logic [DECODE_WIDTH*PLEN-1:0]    de_pc_o,
  output logic [DECODE_WIDTH*PLEN-1:0]    de_pred_npc_o,
  output logic [$clog2(DEPTH):0]          count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [PLEN-1:0] pc_mem    [DEPTH];
  logic [PLEN-1:0] npc_mem   [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic [PW-1:0] slot_off [INSTR_PER_FETCH];
  logic [CW-1:0] n, m, n_enq, m_deq;
  logic          enq, deq;

  // Each kept slot lands at tail + (number of kept slots below it).
  always_comb begin
    n = '0;
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      slot_off[s] = n[PW-1:0];
      if (fe_slot_valid_i[s]) n = n + CW'(1);
    end
  end

  // Ready looks only at the registered count so de_ready_i never reaches fe_ready_o.
  assign fe_ready_o = !rst_i && (count_q <= CW'(DEPTH - INSTR_PER_FETCH));
  assign enq        = fe_valid_i && fe_ready_o && !flush_i;
  assign m          = (count_q < CW'(DECODE_WIDTH)) ? count_q : CW'(DECODE_WIDTH);
  assign deq        = de_ready_i && (m != '0) && !flush_i;
  assign n_enq      = enq ? n : '0;
  assign m_deq      = deq ? m : '0;
  assign count_o    = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + m_deq[PW-1:0];
      tail_q  <= tail_q + n_enq[PW-1:0];
      count_q <= count_q + n_enq - m_deq;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        if (fe_slot_valid_i[s]) begin
          instr_mem[tail_q + slot_off[s]] <= fe_data_i[s*ILEN +: ILEN];
          pc_mem[tail_q + slot_off[s]]    <= fe_pc_i + PLEN'(4 * s);
          npc_mem[tail_q + slot_off[s]]   <= fe_pred_npc_i[s*PLEN +: PLEN];
        end
      end
    end
  end

  always_comb begin
    logic [PW-1:0] rd_idx;
    de_valid_o    = '0;
    de_instr_o    = '0;
    de_pc_o       = '0;
    de_pred_npc_o = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      rd_idx                         = head_q + PW'(i);
      de_valid_o[i]                  = !rst_i && (CW'(i) < m);
      de_instr_o[i*ILEN +: ILEN]     = instr_mem[rd_idx];
      de_pc_o[i*PLEN +: PLEN]        = pc_mem[rd_idx];
      de_pred_npc_o[i*PLEN +: PLEN]  = npc_mem[rd_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (count_q <= CW'(DEPTH));
      assert ((de_valid_o & (de_valid_o + 1'b1)) == '0);
    end
  end

endmodule

// File: tb/tb_ibuffer.sv
// Directed bench for ibuffer: a scoreboard records accepted slots and a monitor
// checks every lane decode consumes, alongside hand-computed occupancy checks.
module tb_ibuffer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         fe_valid_i;
  logic         fe_ready_o;
  logic [127:0] fe_data_i;
  logic [31:0]  fe_pc_i;
  logic [3:0]   fe_slot_valid_i;
  logic [127:0] fe_pred_npc_i;
  logic         flush_i;
  logic [3:0]   de_valid_o;
  logic         de_ready_i;
  logic [127:0] de_instr_o;
  logic [127:0] de_pc_o;
  logic [127:0] de_pred_npc_o;
  logic [4:0]   count_o;

  ibuffer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fe_valid_i(fe_valid_i), .fe_ready_o(fe_ready_o), .fe_data_i(fe_data_i),
    .fe_pc_i(fe_pc_i), .fe_slot_valid_i(fe_slot_valid_i), .fe_pred_npc_i(fe_pred_npc_i),
    .flush_i(flush_i), .de_valid_o(de_valid_o), .de_ready_i(de_ready_i),
    .de_instr_o(de_instr_o), .de_pc_o(de_pc_o), .de_pred_npc_o(de_pred_npc_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  ent_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: drop on flush/reset, check consumed lanes in order, then record accepted slots.
  always @(negedge clk_i) begin
    if (rst_i || flush_i) begin
      exp_q.delete();
    end else begin
      if (de_ready_i) begin
        for (int i = 0; i < 4; i++) begin
          if (de_valid_o[i]) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL scb_underflow: lane %0d valid with no expected entry", i);
            end else begin
              ent_t e;
              e = exp_q.pop_front();
              chk("scb_lane", {de_instr_o[i*32 +: 32], de_pc_o[i*32 +: 32], de_pred_npc_o[i*32 +: 32]}, e);
            end
          end
        end
      end
      if (fe_valid_i && fe_ready_o) begin
        for (int s = 0; s < 4; s++) begin
          if (fe_slot_valid_i[s])
            exp_q.push_back({fe_data_i[s*32 +: 32], fe_pc_i + 32'(4 * s), fe_pred_npc_i[s*32 +: 32]});
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_group(input logic [31:0] pc, input logic [3:0] mask, input logic [31:0] base);
    fe_pc_i         = pc;
    fe_slot_valid_i = mask;
    for (int s = 0; s < 4; s++) begin
      fe_data_i[s*32 +: 32]     = base + 32'(s);
      fe_pred_npc_i[s*32 +: 32] = pc + 32'h1000 + 32'(4 * s);
    end
    fe_valid_i = 1'b1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [3:0] mask, input logic [31:0] base);
    drive_group(pc, mask, base);
    cycle();
    fe_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; fe_valid_i = 1'b0; fe_data_i = '0; fe_pc_i = '0;
    fe_slot_valid_i = '0; fe_pred_npc_i = '0; flush_i = 1'b0; de_ready_i = 1'b0;
    #2;
    chk("rst_ready_low", fe_ready_o, 0);
    chk("rst_valid_low", de_valid_o, 0);
    cycle(); cycle();
    rst_i = 1'b0;
    #1;
    chk("idle_ready", fe_ready_o, 1);
    chk("idle_valid", de_valid_o, 0);
    chk("idle_count", count_o, 0);

    // Full group
    send(32'h8000_0000, 4'b1111, 32'hA000_0000);
    chk("full_valid", de_valid_o, 4'b1111);
    chk("full_pc0", de_pc_o[31:0], 32'h8000_0000);
    chk("full_pc3", de_pc_o[127:96], 32'h8000_000C);
    chk("full_instr0", de_instr_o[31:0], 32'hA000_0000);
    chk("full_instr3", de_instr_o[127:96], 32'hA000_0003);
    de_ready_i = 1'b1; cycle(); de_ready_i = 1'b0;
    chk("full_drained", count_o, 0);

    // Empty mask consumes the group without storing anything
    send(32'h0000_0040, 4'b0000, 32'hEE00_0000);
    chk("mask0_count", count_o, 0);

    // Sparse mask
    send(32'h0000_0100, 4'b1010, 32'h5000_0000);
    chk("sparse_count", count_o, 2);
    chk("sparse_valid", de_valid_o, 4'b0011);
    chk("sparse_l0", {de_instr_o[31:0], de_pc_o[31:0], de_pred_npc_o[31:0]},
        {32'h5000_0001, 32'h0000_0104, 32'h0000_1104});
    chk("sparse_l1", {de_instr_o[63:32], de_pc_o[63:32], de_pred_npc_o[63:32]},
        {32'h5000_0003, 32'h0000_010C, 32'h0000_110C});
    de_ready_i = 1'b1; cycle(); de_ready_i = 1'b0;

    // Fill to full
    for (int g = 0; g < 3; g++) send(32'h1000 + 32'(16 * g), 4'b1111, 32'hB000_0000 + 32'(16 * g));
    chk("fill12_count", count_o, 12);
    chk("fill12_ready", fe_ready_o, 1);
    send(32'h1030, 4'b1111, 32'hB000_0030);
    chk("fill16_count", count_o, 16);
    chk("fill16_ready", fe_ready_o, 0);
    de_ready_i = 1'b1; cycle(); de_ready_i = 1'b0;
    chk("pulse_count", count_o, 12);
    chk("pulse_ready", fe_ready_o, 1);
    de_ready_i = 1'b1; cycle(); cycle(); cycle(); de_ready_i = 1'b0;
    chk("fill_drained", count_o, 0);

    // Head/tail now at 6; advance both to 14, then straddle the wrap
    send(32'h3000, 4'b1111, 32'hC000_0000);
    send(32'h3010, 4'b1111, 32'hC000_0010);
    de_ready_i = 1'b1; cycle(); cycle(); de_ready_i = 1'b0;
    chk("pre_wrap_count", count_o, 0);
    send(32'h4000, 4'b1111, 32'h4400_0000);
    chk("wrap_count", count_o, 4);
    chk("wrap_pc0", de_pc_o[31:0], 32'h4000);
    chk("wrap_pc3", de_pc_o[127:96], 32'h400C);
    chk("wrap_instr2", de_instr_o[95:64], 32'h4400_0002);
    de_ready_i = 1'b1;
    send(32'h4010, 4'b1111, 32'h4400_0010);
    chk("simul_count_a", count_o, 4);
    send(32'h4020, 4'b1111, 32'h4400_0020);
    chk("simul_count_b", count_o, 4);
    chk("simul_pc0", de_pc_o[31:0], 32'h4020);
    cycle(); de_ready_i = 1'b0;
    chk("simul_drained", count_o, 0);

    // Flush beats concurrent enqueue and dequeue
    send(32'h5000, 4'b1111, 32'hD000_0000);
    send(32'h5010, 4'b1111, 32'hD000_0010);
    chk("preflush_count", count_o, 8);
    drive_group(32'h6000, 4'b1111, 32'hF000_0000);
    de_ready_i = 1'b1; flush_i = 1'b1;
    cycle();
    fe_valid_i = 1'b0; de_ready_i = 1'b0; flush_i = 1'b0;
    chk("flush_count", count_o, 0);
    chk("flush_valid", de_valid_o, 0);
    send(32'h2000, 4'b0001, 32'h7700_0000);
    chk("redirect_count", count_o, 1);
    chk("redirect_valid", de_valid_o, 4'b0001);
    chk("redirect_l0", {de_instr_o[31:0], de_pc_o[31:0]}, {32'h7700_0000, 32'h2000});
    de_ready_i = 1'b1; cycle(); de_ready_i = 1'b0;

    // Reset mid-stream behaves like flush
    send(32'h9000, 4'b0111, 32'h9900_0000);
    rst_i = 1'b1;
    #1;
    chk("mrst_ready", fe_ready_o, 0);
    chk("mrst_valid", de_valid_o, 0);
    cycle();
    rst_i = 1'b0;
    #1;
    chk("mrst_count", count_o, 0);
    chk("mrst_ready_after", fe_ready_o, 1);

    chk("scb_empty", 96'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
